// File: rtl/keypad_pkg.sv
// ---------------------------------------------------------------------------
// keypad_pkg
// Shared definitions for the matrix keypad scanner:
//   NO_KEY     - all-ones code reported when no single key is held; modules
//                take the low CODE_W bits.
//   key_state_e - debounce FSM states (IDLE: no key accepted, HELD: key accepted).
//   phone_map  - telephone layout for a 4x3 pad:
//                row0 1,2,3 / row1 4,5,6 / row2 7,8,9 / row3 *(12),0,#(11).
// ---------------------------------------------------------------------------
package keypad_pkg;

    localparam logic [31:0] NO_KEY = '1;

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } key_state_e;

    function automatic logic [3:0] phone_map(input int unsigned row, input int unsigned col);
        logic [3:0] code;
        code = 4'hF;
        case (row)
            0, 1, 2: code = 4'(row * 3 + col + 1);
            default: begin
                case (col)
                    0:       code = 4'd12;
                    1:       code = 4'd0;
                    default: code = 4'd11;
                endcase
            end
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_frame_debounce.sv
// ---------------------------------------------------------------------------
// keypad_frame_debounce
// Frame-level debouncer and press/release FSM. Each frame result is compared
// with a candidate; once the candidate has been seen DEBOUNCE_FRAMES frames
// in a row and differs from the reported key, the outputs change on the
// following cycle.
// Ports:
//   clk              in   system clock
//   rst              in   asynchronous active-high reset
//   i_frame_done     in   1-cycle pulse at the end of each scan frame
//   i_frame_result   in   decoded frame result (NO_KEY for none / ghost)
//   o_key_code       out  accepted key code, NO_KEY when idle
//   o_key_valid      out  high while a key is accepted
//   o_key_press      out  1-cycle strobe on a newly accepted key
//   o_key_release    out  1-cycle strobe when the accepted key is lost/replaced
// ---------------------------------------------------------------------------
module keypad_frame_debounce
    import keypad_pkg::*;
#(
    parameter int CODE_W          = 4,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_frame_done,
    input  logic [CODE_W-1:0] i_frame_result,
    output logic [CODE_W-1:0] o_key_code,
    output logic              o_key_valid,
    output logic              o_key_press,
    output logic              o_key_release
);

    localparam int                CNT_W     = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(DEBOUNCE_FRAMES);
    localparam logic [CODE_W-1:0] NO_KEY_C  = NO_KEY[CODE_W-1:0];

    logic [CODE_W-1:0] r_cand;
    logic [CNT_W-1:0]  r_count;
    key_state_e        r_state;
    logic [CODE_W-1:0] r_key_code;
    logic              r_key_valid;
    logic              r_key_press;
    logic              r_key_release;

    key_state_e        w_state_nxt;
    logic [CODE_W-1:0] w_code_nxt;
    logic              w_valid_nxt;
    logic              w_press_nxt;
    logic              w_release_nxt;
    logic              w_accept;

    // A stable candidate that differs from the reported key is accepted.
    // After an accept the two match, so the next accept needs a new
    // candidate, which only appears at a later frame end.
    assign w_accept = (r_count == CNT_FULL) && (r_cand != r_key_code);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cand  <= NO_KEY_C;
            r_count <= '0;
        end else if (i_frame_done) begin
            if (i_frame_result == r_cand) begin
                if (r_count != CNT_FULL) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end else begin
                r_cand  <= i_frame_result;
                r_count <= CNT_W'(1);
            end
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        w_state_nxt   = r_state;
        w_code_nxt    = r_key_code;
        w_valid_nxt   = r_key_valid;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        if (w_accept) begin
            case (r_state)
                IDLE: begin
                    w_code_nxt  = r_cand;
                    w_valid_nxt = 1'b1;
                    w_press_nxt = 1'b1;
                    w_state_nxt = HELD;
                end
                HELD: begin
                    w_release_nxt = 1'b1;
                    if (r_cand == NO_KEY_C) begin
                        w_code_nxt  = NO_KEY_C;
                        w_valid_nxt = 1'b0;
                        w_state_nxt = IDLE;
                    end else begin
                        // Roll-over: old key released and new key pressed together.
                        w_code_nxt  = r_cand;
                        w_press_nxt = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_key_code    <= NO_KEY_C;
            r_key_valid   <= 1'b0;
            r_key_press   <= 1'b0;
            r_key_release <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_key_code    <= w_code_nxt;
            r_key_valid   <= w_valid_nxt;
            r_key_press   <= w_press_nxt;
            r_key_release <= w_release_nxt;
        end
    end

    assign o_key_code    = r_key_code;
    assign o_key_valid   = r_key_valid;
    assign o_key_press   = r_key_press;
    assign o_key_release = r_key_release;

endmodule

// File: rtl/matrix_keypad_scanner.sv
// ---------------------------------------------------------------------------
// matrix_keypad_scanner
// Scans a ROWS x COLS switch matrix: drives one row at a time (one-hot,
// rotating toward bit 0), samples synchronised column lines at the end of
// each row dwell, and builds a per-frame result (single key -> its code,
// none or several -> NO_KEY). Debounce and strobes live in
// keypad_frame_debounce.
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   col_in       in   column sense (active-high, async); col_in[COLS-1] = column 0
//   row_drive    out  one-hot row drive; row_drive[ROWS-1] = row 0
//   key_code     out  accepted key code, all-ones when no key
//   key_valid    out  high while a key is accepted
//   key_press    out  1-cycle strobe on a newly accepted key
//   key_release  out  1-cycle strobe when the accepted key is lost/replaced
// ---------------------------------------------------------------------------
module matrix_keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS            = 4,
    parameter int COLS            = 3,
    parameter int CODE_W          = 4,
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int MAP_PHONE       = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [COLS-1:0]   col_in,
    output logic [ROWS-1:0]   row_drive,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_press,
    output logic              key_release
);

    localparam int                 DWELL_W    = $clog2(SCAN_DIV);
    localparam int                 ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SCAN_DIV - 1);
    localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS - 1);
    localparam logic [CODE_W-1:0]  NO_KEY_C   = NO_KEY[CODE_W-1:0];

    logic [COLS-1:0]    r_col_meta;
    logic [COLS-1:0]    r_col_sync;
    logic [DWELL_W-1:0] r_dwell;
    logic [ROWS-1:0]    r_row_drive;
    logic [ROW_W-1:0]   r_row_idx;
    logic [1:0]         r_acc_hits;   // 0, 1, or 2 meaning "two or more"
    logic [CODE_W-1:0]  r_acc_code;

    logic [1:0]         w_row_hits;
    int unsigned        w_row_col;
    logic [CODE_W-1:0]  w_hit_code;
    logic [2:0]         w_sum_hits;
    logic [1:0]         w_total_hits;
    logic [CODE_W-1:0]  w_new_code;
    logic               w_sample;
    logic               w_frame_done;
    logic [CODE_W-1:0]  w_frame_result;

    // Hits on the current row; column numbering is reversed against bit order.
    always_comb begin
        w_row_hits = 2'd0;
        w_row_col  = 0;
        for (int c = 0; c < COLS; c++) begin
            if (r_col_sync[COLS-1-c]) begin
                if (w_row_hits != 2'd2) begin
                    w_row_hits = w_row_hits + 2'd1;
                end
                w_row_col = c;
            end
        end
    end

    always_comb begin
        if (MAP_PHONE != 0) begin
            w_hit_code = CODE_W'(phone_map(32'(r_row_idx), w_row_col));
        end else begin
            w_hit_code = CODE_W'(32'(r_row_idx) * COLS + w_row_col);
        end
    end

    // Fold this row into the frame totals; the result includes the row
    // sampled on the frame-end cycle itself.
    assign w_sum_hits     = {1'b0, r_acc_hits} + {1'b0, w_row_hits};
    assign w_total_hits   = (w_sum_hits > 3'd2) ? 2'd2 : w_sum_hits[1:0];
    assign w_new_code     = (r_acc_hits == 2'd0 && w_row_hits == 2'd1) ? w_hit_code : r_acc_code;
    assign w_sample       = (r_dwell == DWELL_LAST);
    assign w_frame_done   = w_sample && (r_row_idx == ROW_LAST);
    assign w_frame_result = (w_total_hits == 2'd1) ? w_new_code : NO_KEY_C;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col_meta  <= '0;
            r_col_sync  <= '0;
            r_dwell     <= '0;
            r_row_drive <= {1'b1, {(ROWS-1){1'b0}}};
            r_row_idx   <= '0;
            r_acc_hits  <= 2'd0;
            r_acc_code  <= NO_KEY_C;
        end else begin
            r_col_meta <= col_in;
            r_col_sync <= r_col_meta;
            if (w_sample) begin
                r_dwell     <= '0;
                r_row_drive <= {r_row_drive[0], r_row_drive[ROWS-1:1]};
                r_row_idx   <= (r_row_idx == ROW_LAST) ? '0 : r_row_idx + ROW_W'(1);
                if (w_frame_done) begin
                    r_acc_hits <= 2'd0;
                    r_acc_code <= NO_KEY_C;
                end else begin
                    r_acc_hits <= w_total_hits;
                    r_acc_code <= w_new_code;
                end
            end else begin
                r_dwell <= r_dwell + DWELL_W'(1);
            end
        end
    end

    assign row_drive = r_row_drive;

    keypad_frame_debounce #(
        .CODE_W          (CODE_W),
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES)
    ) u_debounce (
        .clk            (clk),
        .rst            (rst),
        .i_frame_done   (w_frame_done),
        .i_frame_result (w_frame_result),
        .o_key_code     (key_code),
        .o_key_valid    (key_valid),
        .o_key_press    (key_press),
        .o_key_release  (key_release)
    );

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// ---------------------------------------------------------------------------
// tb_matrix_keypad_scanner
// Directed bench for the keypad scanner (SCAN_DIV=4, DEBOUNCE_FRAMES=2,
// 4x3 pad, frame = 16 clk). A telephone-map instance and a raw-index
// instance share clock and reset; a behavioural key matrix turns the
// row drive plus a set of held keys into column levels. Expected strobe
// events are queued when keys change and consumed by per-instance monitors.
// ---------------------------------------------------------------------------
module tb_matrix_keypad_scanner;

    typedef struct packed {
        logic       press;
        logic       rel;
        logic [3:0] code;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0] col_main, col_raw;
    logic [3:0] row_main, row_raw;
    logic [3:0] code_main, code_raw;
    logic       valid_main, valid_raw;
    logic       press_main, press_raw;
    logic       rel_main, rel_raw;

    logic [3:0][2:0] pressed_main = '0;
    logic [3:0][2:0] pressed_raw  = '0;

    int  checks = 0;
    int  failures = 0;
    int  strobes_main = 0;
    int  strobes_raw = 0;
    int  cyc;
    int  used;
    int  s0;
    ev_t exp_main_q[$];
    ev_t exp_raw_q[$];
    ev_t mon_main, exp_main_ev, mon_raw, exp_raw_ev;
    logic [3:0] ring [5];

    matrix_keypad_scanner #(
        .ROWS(4), .COLS(3), .CODE_W(4), .SCAN_DIV(4), .DEBOUNCE_FRAMES(2), .MAP_PHONE(1)
    ) dut (
        .clk(clk), .rst(rst), .col_in(col_main), .row_drive(row_main),
        .key_code(code_main), .key_valid(valid_main),
        .key_press(press_main), .key_release(rel_main)
    );

    matrix_keypad_scanner #(
        .ROWS(4), .COLS(3), .CODE_W(4), .SCAN_DIV(4), .DEBOUNCE_FRAMES(2), .MAP_PHONE(0)
    ) dut_raw (
        .clk(clk), .rst(rst), .col_in(col_raw), .row_drive(row_raw),
        .key_code(code_raw), .key_valid(valid_raw),
        .key_press(press_raw), .key_release(rel_raw)
    );

    // Switch matrix: a held key connects its row drive to its column line.
    always_comb begin
        col_main = '0;
        col_raw  = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (row_main[3-r] && pressed_main[r][c]) col_main[2-c] = 1'b1;
                if (row_raw[3-r] && pressed_raw[r][c])   col_raw[2-c]  = 1'b1;
            end
        end
    end

    // Cycles since reset release; a multiple of 16 marks a frame start.
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (press_main || rel_main)) begin
            strobes_main++;
            mon_main = {press_main, rel_main, code_main};
            if (exp_main_q.size() == 0) begin
                check("main_unexpected_strobe", 32'(mon_main), 32'h0);
            end else begin
                exp_main_ev = exp_main_q.pop_front();
                check("main_strobe", 32'(mon_main), 32'(exp_main_ev));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && (press_raw || rel_raw)) begin
            strobes_raw++;
            mon_raw = {press_raw, rel_raw, code_raw};
            if (exp_raw_q.size() == 0) begin
                check("raw_unexpected_strobe", 32'(mon_raw), 32'h0);
            end else begin
                exp_raw_ev = exp_raw_q.pop_front();
                check("raw_strobe", 32'(mon_raw), 32'(exp_raw_ev));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic align();
        @(negedge clk);
        while (cyc % 16 != 0) @(negedge clk);
    endtask

    // Wait (bounded) until the selected queue is consumed; a timeout is a failure.
    task automatic drain(input string tag, input bit raw, input int budget, output int n);
        n = 0;
        while (((raw ? exp_raw_q.size() : exp_main_q.size()) != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(raw ? exp_raw_q.size() : exp_main_q.size()), 32'h0);
        if (raw) exp_raw_q.delete();
        else     exp_main_q.delete();
    endtask

    initial begin
        ring = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};

        // 1: reset values, then row rotation every 4 clk
        tick(3);
        check("rst_row_drive", 32'(row_main), 32'h8);
        check("rst_key_code", 32'(code_main), 32'hF);
        check("rst_key_valid", 32'(valid_main), 32'h0);
        check("rst_key_press", 32'(press_main), 32'h0);
        check("rst_key_release", 32'(rel_main), 32'h0);
        check("rst_raw_key_code", 32'(code_raw), 32'hF);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("ring_dwell_start", 32'(row_main), 32'(ring[k]));
            tick(3);
            check("ring_dwell_end", 32'(row_main), 32'(ring[k]));
            tick(1);
        end
        check("idle_key_code", 32'(code_main), 32'hF);
        check("idle_strobes", 32'(strobes_main + strobes_raw), 32'h0);

        // 2: press and release '6'
        align();
        pressed_main[1][2] = 1'b1;
        exp_main_q.push_back('{press: 1'b1, rel: 1'b0, code: 4'd6});
        drain("t2_press_seen", 1'b0, 45, used);
        check("t2_press_latency", 32'(used <= 35), 32'h1);
        check("t2_key_code", 32'(code_main), 32'h6);
        check("t2_key_valid", 32'(valid_main), 32'h1);
        pressed_main = '0;
        exp_main_q.push_back('{press: 1'b0, rel: 1'b1, code: 4'hF});
        drain("t2_release_seen", 1'b0, 70, used);
        check("t2_release_not_early", 32'(used >= 20), 32'h1);
        check("t2_key_code_released", 32'(code_main), 32'hF);
        check("t2_key_valid_released", 32'(valid_main), 32'h0);
        tick(32);

        // 3: bouncing '5' never settles
        align();
        s0 = strobes_main;
        for (int i = 0; i < 10; i++) begin
            pressed_main[1][1] = (i % 2 == 0);
            tick(5);
        end
        pressed_main = '0;
        tick(48);
        check("t3_no_strobe", 32'(strobes_main - s0), 32'h0);
        check("t3_key_code", 32'(code_main), 32'hF);

        // 4: ghost '1'+'5' rejected, then '1' alone accepted
        align();
        s0 = strobes_main;
        pressed_main[0][0] = 1'b1;
        pressed_main[1][1] = 1'b1;
        tick(64);
        check("t4_ghost_no_strobe", 32'(strobes_main - s0), 32'h0);
        check("t4_ghost_key_code", 32'(code_main), 32'hF);
        pressed_main[1][1] = 1'b0;
        exp_main_q.push_back('{press: 1'b1, rel: 1'b0, code: 4'd1});
        drain("t4_press_seen", 1'b0, 45, used);
        check("t4_key_code", 32'(code_main), 32'h1);
        pressed_main = '0;
        exp_main_q.push_back('{press: 1'b0, rel: 1'b1, code: 4'hF});
        drain("t4_release_seen", 1'b0, 70, used);
        tick(16);

        // 5: roll-over '2' -> '8'
        align();
        pressed_main[0][1] = 1'b1;
        exp_main_q.push_back('{press: 1'b1, rel: 1'b0, code: 4'd2});
        drain("t5_press2_seen", 1'b0, 45, used);
        check("t5_key_code_2", 32'(code_main), 32'h2);
        align();
        pressed_main = '0;
        pressed_main[2][1] = 1'b1;
        exp_main_q.push_back('{press: 1'b1, rel: 1'b1, code: 4'd8});
        drain("t5_rollover_seen", 1'b0, 45, used);
        check("t5_key_code_8", 32'(code_main), 32'h8);
        check("t5_key_valid", 32'(valid_main), 32'h1);
        pressed_main = '0;
        exp_main_q.push_back('{press: 1'b0, rel: 1'b1, code: 4'hF});
        drain("t5_release_seen", 1'b0, 70, used);
        tick(16);

        // 6: reset while '9' accepted, fresh press after release of reset
        align();
        pressed_main[2][2] = 1'b1;
        exp_main_q.push_back('{press: 1'b1, rel: 1'b0, code: 4'd9});
        drain("t6_press_seen", 1'b0, 45, used);
        check("t6_key_code", 32'(code_main), 32'h9);
        tick(5);
        rst = 1'b1;
        #1;
        check("t6_rst_key_code", 32'(code_main), 32'hF);
        check("t6_rst_key_valid", 32'(valid_main), 32'h0);
        check("t6_rst_row_drive", 32'(row_main), 32'h8);
        check("t6_rst_strobes", 32'({press_main, rel_main}), 32'h0);
        tick(3);
        rst = 1'b0;
        exp_main_q.push_back('{press: 1'b1, rel: 1'b0, code: 4'd9});
        drain("t6_press_after_reset", 1'b0, 45, used);
        check("t6_press_latency", 32'(used <= 35), 32'h1);
        check("t6_press_not_early", 32'(used >= 20), 32'h1);
        pressed_main = '0;
        exp_main_q.push_back('{press: 1'b0, rel: 1'b1, code: 4'hF});
        drain("t6_release_seen", 1'b0, 70, used);
        tick(16);

        // 7: raw index map, '*' (row3, col0) -> 9
        align();
        s0 = strobes_main;
        pressed_raw[3][0] = 1'b1;
        exp_raw_q.push_back('{press: 1'b1, rel: 1'b0, code: 4'd9});
        drain("t7_raw_press_seen", 1'b1, 45, used);
        check("t7_raw_key_code", 32'(code_raw), 32'h9);
        check("t7_raw_key_valid", 32'(valid_raw), 32'h1);
        pressed_raw = '0;
        exp_raw_q.push_back('{press: 1'b0, rel: 1'b1, code: 4'hF});
        drain("t7_raw_release_seen", 1'b1, 70, used);
        check("t7_raw_key_code_released", 32'(code_raw), 32'hF);
        tick(16);
        check("t7_main_quiet", 32'(strobes_main - s0), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
